// File: rtl/lfsr_sequence_checker.sv
// Receive-side checker for the 32-bit Fibonacci LFSR stream (taps 31,6,5,1).
// Optional feature macro: LFSR_CHECK_BIT_COUNT_EN enables the locked bit counter.
module lfsr_sequence_checker #(
    parameter int LOCK_COUNT     = 32,
    parameter int WINDOW         = 256,
    parameter int LOSS_THRESHOLD = 8,
    parameter int ERR_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 bit_error,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic [31:0]          bit_count
);
    localparam int MC_W  = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TH_W  = $clog2(LOSS_THRESHOLD + 1);

    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [TH_W-1:0]  TH_HIT   = TH_W'(LOSS_THRESHOLD);

    typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

    state_t           state;
    logic [31:0]      h;
    logic [5:0]       fill_cnt;
    logic [MC_W-1:0]  match_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [TH_W-1:0]  win_err;

    logic             pred;
    logic             hit;
    logic             win_wrap;
    logic             loss;
    logic [TH_W-1:0]  win_err_inc;

    assign pred        = h[31] ^ h[6] ^ h[5] ^ h[1];
    assign hit         = (in == pred);
    assign win_wrap    = (win_cnt == WIN_LAST);
    assign win_err_inc = win_err + TH_W'(1);
    assign loss        = !hit && (win_err_inc == TH_HIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FILL;
            h           <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            locked      <= 1'b0;
            bit_error   <= 1'b0;
            error_count <= '0;
        end else begin
            bit_error <= 1'b0;
            if (clear_count)
                error_count <= '0;
            if (in_valid) begin
                unique case (state)
                    FILL: begin
                        h <= {h[30:0], in};
                        if (fill_cnt == 6'd31) begin
                            fill_cnt <= '0;
                            state    <= VERIFY;
                        end else begin
                            fill_cnt <= fill_cnt + 6'd1;
                        end
                    end
                    VERIFY: begin
                        // Resync on the raw stream; an all-zero history never counts as a match.
                        h <= {h[30:0], in};
                        if (hit && (h != '0)) begin
                            if (match_cnt == MC_LAST) begin
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                                locked    <= 1'b1;
                                state     <= LOCKED;
                            end else begin
                                match_cnt <= match_cnt + MC_W'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on our own prediction so a flipped bit stays a single error.
                        h       <= {h[30:0], pred};
                        win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
                        if (!hit) begin
                            bit_error <= 1'b1;
                            if (!clear_count && (error_count != '1))
                                error_count <= error_count + ERR_WIDTH'(1);
                            if (loss) begin
                                state     <= FILL;
                                locked    <= 1'b0;
                                fill_cnt  <= '0;
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                            end else begin
                                win_err <= win_wrap ? '0 : win_err_inc;
                            end
                        end else if (win_wrap) begin
                            win_err <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

`ifdef LFSR_CHECK_BIT_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            bit_count <= '0;
        else if (in_valid && (state == LOCKED) && (bit_count != '1))
            bit_count <= bit_count + 32'd1;
    end
`else
    assign bit_count = '0;
`endif

endmodule
